mul_rr_sequencer: RTL and testbench

- Sequencer and round-robin arbiter that shares one repeated-addition multiplier datapath (A/B/P registers, shared data bus, decB, eqz) between two requesters.
- Accepts operand pairs, loads them onto the datapath over its shared input bus, steps LdP/decB until eqz, then returns the product with a one-cycle ack.
- Sits between client logic and the existing datapath, in place of the single-user start/done controller.

---
 rtl/mul_seq_pkg.sv | 15 +
 rtl/mul_rr_arb2.sv | 33 +++
 rtl/mul_rr_sequencer.sv | 123 ++++++++++++
 tb/tb_mul_rr_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared definitions for the two-requester repeated-addition multiplier sequencer.
package mul_seq_pkg;

    localparam int unsigned W_DEFAULT = 16;
    localparam int unsigned STATE_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/mul_rr_arb2.sv
// Two-input round-robin arbiter: on a tie, grants the requester that was not served last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_id,
    output logic       gnt_c,
    output logic       any_c
);

    logic last;

    // Pointer starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (upd) begin
            last <= upd_id;
        end
    end

    always_comb begin
        any_c = |req;
        gnt_c = 1'b0;
        if (req[0] && req[1]) begin
            gnt_c = ~last;
        end else begin
            gnt_c = req[1];
        end
    end

endmodule

// File: rtl/mul_rr_sequencer.sv
// Sequencer sharing one repeated-addition multiplier datapath between two round-robin requesters.
module mul_rr_sequencer
    import mul_seq_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    output logic         ack0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         ack1,
    output logic [W-1:0] result,
    output logic         busy,
    output logic         gnt_id,
    output logic [W-1:0] dp_bus,
    output logic         ld_a,
    output logic         ld_b,
    output logic         ld_p,
    output logic         clr_p,
    output logic         dec_b,
    input  logic         eqz,
    input  logic [W-1:0] p_in
);

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         arb_gnt_c;
    logic         arb_any_c;
    logic         grant_c;
    logic         upd_c;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1, req0}),
        .upd    (upd_c),
        .upd_id (gnt_id),
        .gnt_c  (arb_gnt_c),
        .any_c  (arb_any_c)
    );

    // State, operand latches (captured at grant) and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            gnt_id <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
        end else begin
            state <= state_nxt;
            if (grant_c) begin
                gnt_id <= arb_gnt_c;
                op_a   <= arb_gnt_c ? a1 : a0;
                op_b   <= arb_gnt_c ? b1 : b0;
            end
            if (state == S_RUN && eqz) begin
                result <= p_in;
            end
        end
    end

    // Next state and datapath strobes decoded from the registered state.
    always_comb begin
        state_nxt = state;
        grant_c   = 1'b0;
        upd_c     = 1'b0;
        dp_bus    = '0;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_p      = 1'b0;
        clr_p     = 1'b0;
        dec_b     = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        case (state)
            S_IDLE: begin
                if (arb_any_c) begin
                    grant_c   = 1'b1;
                    state_nxt = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                dp_bus    = op_a;
                ld_a      = 1'b1;
                state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                dp_bus    = op_b;
                ld_b      = 1'b1;
                clr_p     = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (eqz) begin
                    state_nxt = S_DONE;
                end else begin
                    ld_p  = 1'b1;
                    dec_b = 1'b1;
                end
            end
            S_DONE: begin
                ack0      = ~gnt_id;
                ack1      = gnt_id;
                upd_c     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mul_rr_sequencer.sv
// Scoreboard bench for mul_rr_sequencer driving a behavioural repeated-addition datapath.
module tb_mul_rr_sequencer;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         ack0, ack1;
    logic [W-1:0] result;
    logic         busy, gnt_id;
    logic [W-1:0] dp_bus;
    logic         ld_a, ld_b, ld_p, clr_p, dec_b;
    logic         eqz;
    logic [W-1:0] p_in;

    logic [W-1:0] reg_a, reg_b, reg_p;

    typedef struct packed {
        logic         id;
        logic [W-1:0] res;
        logic [31:0]  np;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   np_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_rr_sequencer #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .a0     (a0),
        .b0     (b0),
        .ack0   (ack0),
        .req1   (req1),
        .a1     (a1),
        .b1     (b1),
        .ack1   (ack1),
        .result (result),
        .busy   (busy),
        .gnt_id (gnt_id),
        .dp_bus (dp_bus),
        .ld_a   (ld_a),
        .ld_b   (ld_b),
        .ld_p   (ld_p),
        .clr_p  (clr_p),
        .dec_b  (dec_b),
        .eqz    (eqz),
        .p_in   (p_in)
    );

    // Existing multiplier datapath: A, B (down-counter), P (accumulator).
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_a <= '0;
            reg_b <= '0;
            reg_p <= '0;
        end else begin
            if (ld_a) reg_a <= dp_bus;
            if (ld_b) reg_b <= dp_bus;
            else if (dec_b) reg_b <= reg_b - 16'd1;
            if (clr_p) reg_p <= '0;
            else if (ld_p) reg_p <= reg_p + reg_a;
        end
    end
    assign eqz  = (reg_b == '0);
    assign p_in = reg_p;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: structural strobe checks every cycle, scoreboard pop on every ack.
    always @(negedge clk) begin
        if (!rst) begin
            chk("strobes", {28'd0, ld_a && ld_b, ld_p != dec_b,
                            !(ld_a || ld_b) && (dp_bus != '0), ack0 && ack1}, 32'd0);
            if (ld_p) np_cnt++;
            if (ack0 || ack1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b expected none", ack0, ack1);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ack_id", {31'd0, ack1}, {31'd0, mon_e.id});
                    chk("gnt_id", {31'd0, gnt_id}, {31'd0, mon_e.id});
                    chk("result", {16'd0, result}, {16'd0, mon_e.res});
                    chk("ldp_cycles", np_cnt, mon_e.np);
                end
            end
            if (!busy) np_cnt = 0;
        end
    end

    task automatic push_exp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.id  = id;
        e.res = 16'(32'(a) * 32'(b));
        e.np  = 32'(b);
        sb.push_back(e);
    endtask

    task automatic wait_ack(input logic id, output int at);
        at = -1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (id ? ack1 : ack0) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL ack_timeout: got no ack%0d expected one within 1000 cycles", id);
        end
    endtask

    // One job from an idle DUT; operands are scrambled after grant to prove they were latched.
    task automatic single(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit drop_early);
        int c;
        int at;
        push_exp(id, a, b);
        if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
        else    begin req0 = 1'b1; a0 = a; b0 = b; end
        c = cyc;
        @(negedge clk);
        @(negedge clk);
        if (id) begin a1 = ~a; b1 = b + 16'd3; if (drop_early) req1 = 1'b0; end
        else    begin a0 = ~a; b0 = b + 16'd3; if (drop_early) req0 = 1'b0; end
        wait_ack(id, at);
        if (at >= 0) chk("latency", at - c, 32'(b) + 32'd4);
        if (id) req1 = 1'b0; else req0 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int got;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_acks", {30'd0, ack1, ack0}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_gnt_id", {31'd0, gnt_id}, 32'd0);
        chk("rst_strobes", {27'd0, ld_a, ld_b, ld_p, clr_p, dec_b}, 32'd0);
        chk("rst_dp_bus", {16'd0, dp_bus}, 32'd0);
        rst = 1'b0;

        single(1'b0, 16'd17, 16'd5, 1'b0);
        single(1'b1, 16'd9, 16'd0, 1'b1);

        // Simultaneous requests: requester 0 first (requester 1 was served last).
        push_exp(1'b0, 16'd3, 16'd4);
        push_exp(1'b1, 16'd6, 16'd2);
        req0 = 1'b1; a0 = 16'd3; b0 = 16'd4;
        req1 = 1'b1; a1 = 16'd6; b1 = 16'd2;
        got = 0;
        for (int k = 0; k < 200 && got < 2; k++) begin
            @(negedge clk);
            if (ack0) begin req0 = 1'b0; got++; end
            if (ack1) begin req1 = 1'b0; got++; end
        end
        chk("pair_acks", got, 32'd2);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        // Both held for four jobs: grants must alternate 0,1,0,1.
        push_exp(1'b0, 16'd5, 16'd3);
        push_exp(1'b1, 16'd7, 16'd2);
        push_exp(1'b0, 16'd5, 16'd3);
        push_exp(1'b1, 16'd7, 16'd2);
        req0 = 1'b1; a0 = 16'd5; b0 = 16'd3;
        req1 = 1'b1; a1 = 16'd7; b1 = 16'd2;
        got = 0;
        for (int k = 0; k < 500 && got < 4; k++) begin
            @(negedge clk);
            if (ack0 || ack1) got++;
        end
        chk("fair_acks", got, 32'd4);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        // Reset in the middle of RUN aborts the job with no ack.
        req0 = 1'b1; a0 = 16'd7; b0 = 16'd10;
        got = 0;
        for (int k = 0; k < 50 && got < 3; k++) begin
            @(negedge clk);
            if (ld_p) got++;
        end
        chk("abort_in_run", got, 32'd3);
        rst = 1'b1;
        req0 = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_strobes", {27'd0, ld_a, ld_b, ld_p, clr_p, dec_b}, 32'd0);
        chk("abort_acks", {30'd0, ack1, ack0}, 32'd0);
        chk("abort_result", {16'd0, result}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        single(1'b0, 16'd2, 16'd3, 1'b0);

        // Product wraps modulo 2^16.
        single(1'b0, 16'd300, 16'd300, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
